reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter BOOT_EN, default 1, enables the post-reset default-table load.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req / a_we  input  1/1  SPI-side request / write-not-read; a_addr, a_wdata held stable while a_req=1.
REQ-005 a_addr  input  6; a_wdata  input  8; a_gnt  output 1; a_rvalid  output 1; a_rdata  output 8; a_err  output 1.
REQ-006 b_req, b_we, b_addr[6], b_wdata[8], b_gnt, b_rvalid, b_rdata[8], b_err: second requester port (internal/debug), identical semantics to port A.
REQ-007 read, write  output  1/1  one-cycle strobes to the register file.
REQ-008 addr  output  6; data_write  output  8; data_read  input  8 (combinational read data for addr).
REQ-009 boot_done  output  1  high once the default-table load has finished (or immediately if BOOT_EN=0).

Function
REQ-010 States: BOOT, ARB, ISSUE; reset enters BOOT; BOOT with BOOT_EN=0 exits to ARB on the first clock.
REQ-011 BOOT: one write per cycle from BOOT_TABLE, index 0..BOOT_LEN-1; write=1, addr/data_write from the entry; after the last entry, go to ARB and set boot_done.
REQ-012 During BOOT, a_gnt = b_gnt = 0; pending requests are held and served after BOOT completes.
REQ-013 ARB: with no request, stay in ARB and hold read = write = 0; with one request, select it; with both, select the port not granted last.
REQ-014 Round-robin pointer resets to "B last", so A wins the first contention.
REQ-015 ARB -> ISSUE latches the selected port's we/addr/wdata; ISSUE lasts exactly one cycle and then returns to ARB.
REQ-016 ISSUE with addr <= MAX_ADDR: read = ~we, write = we, addr/data_write driven from the latch, x_gnt = 1 for that cycle only.
REQ-017 ISSUE with addr > MAX_ADDR: no read/write strobe; x_gnt = 1 and x_err = 1 in the same cycle; read data returns 0x00.
REQ-018 Read: data_read is sampled in ISSUE; x_rvalid = 1 for one cycle, the cycle after ISSUE; x_rdata is valid with it and holds until the next read on that port.
REQ-019 Writes produce no rvalid; latency from req to gnt is 2 cycles uncontended; peak throughput is one access per 2 cycles.
REQ-020 A requester may deassert req only after gnt; a req still high in the cycle after gnt is treated as a new request.
REQ-021 When not in ISSUE/BOOT-write: read, write, gnt and err are 0; addr and data_write hold 0x00.
REQ-022 Arbitration uses only sampled req; a request arriving during ISSUE is considered in the following ARB cycle.

Reset
REQ-023 rst_n low (any state, including mid-ISSUE) forces: all strobes, gnt, rvalid, err = 0; rdata, addr, data_write = 0x00; boot_done = 0; state BOOT; index 0; pointer "B last".
REQ-024 No partial access completes across reset; an interrupted BOOT restarts from index 0.

Structure
REQ-025 Shared package pwm_pkg holds ADDR_W=6, DATA_W=8, MAX_ADDR=6'h1F, BOOT_LEN=4 and BOOT_TABLE.
REQ-026 BOOT_TABLE contents: {0x00:0x00, 0x02:0xFF, 0x03:0x00, 0x04:0x01}.
REQ-027 The two-way fair picker is a sub-module rr_arb2 (inputs req_a, req_b, advance; output sel; internal last-grant flop).
REQ-028 Boot index counter width is $clog2(BOOT_LEN); no other sub-modules.

Verification
REQ-029 Reset release, BOOT_EN=1 -> writes to addresses 0x00, 0x02, 0x03, 0x04 with data 0x00, 0xFF, 0x00, 0x01 on 4 consecutive cycles; boot_done=1 on the 5th cycle.
REQ-030 a_req read of addr 0x03 (register holds 0x5A) -> a_gnt 2 cycles later with read=1, addr=0x03; a_rvalid the next cycle with a_rdata=0x5A.
REQ-031 a_req and b_req simultaneous (both writes, 0x11 to 0x05 and 0x22 to 0x06) -> A served first, B served 2 cycles later; a repeat contention serves B first.
REQ-032 b_req read of addr 0x25 -> b_gnt=b_err=1, no read strobe, b_rvalid next cycle with b_rdata=0x00.
REQ-033 a_req asserted during BOOT -> no a_gnt until boot_done=1; first ISSUE after BOOT serves A.
REQ-034 rst_n asserted during ISSUE of a write -> write drops immediately; after release, BOOT restarts at index 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, limits, boot table and state type for reg_arbiter
package pwm_pkg;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 6'h1F;
    localparam int BOOT_LEN   = 4;
    localparam int BOOT_IDX_W = $clog2(BOOT_LEN);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } boot_entry_t;

    // Entry 0 is the rightmost element of the concatenation.
    localparam boot_entry_t [BOOT_LEN-1:0] BOOT_TABLE = {
        {6'h04, 8'h01},
        {6'h03, 8'h00},
        {6'h02, 8'hFF},
        {6'h00, 8'h00}
    };

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ARB   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;
endpackage

// File: rtl/reg_arbiter_if.sv
// rtl/reg_arbiter_if.sv - one requester port of the register arbiter
interface reg_arbiter_if;
    import pwm_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way fair picker; sel=1 selects requester B
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic sel
);
    logic r_last_b;

    assign sel = req_b & (~req_a | ~r_last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (advance) begin
            r_last_b <= sel;
        end
    end
endmodule

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - boots the register file from a table, then arbitrates two requesters onto it
module reg_arbiter
    import pwm_pkg::*;
#(
    parameter bit BOOT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_arbiter_if.slave      a,
    reg_arbiter_if.slave      b,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              boot_done
);
    state_t                r_state, w_next;
    logic [BOOT_IDX_W-1:0] r_idx;
    logic                  r_boot_go;
    logic                  r_boot_done;
    logic                  r_a_req, r_b_req;
    logic                  r_sel;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_a_rvalid, r_b_rvalid;
    logic [DATA_W-1:0]     r_a_rdata, r_b_rdata;

    logic                  w_sel, w_any, w_advance, w_in_range, w_issue_a, w_issue_b;
    boot_entry_t           w_boot;

    assign w_any      = r_a_req | r_b_req;
    // The fairness pointer only moves on real contention, so a lone request never steals a turn.
    assign w_advance  = (r_state == S_ARB) & r_a_req & r_b_req;
    assign w_in_range = (r_addr <= MAX_ADDR);
    assign w_issue_a  = (r_state == S_ISSUE) & ~r_sel;
    assign w_issue_b  = (r_state == S_ISSUE) & r_sel;
    assign w_boot     = BOOT_TABLE[r_idx];

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (r_a_req),
        .req_b   (r_b_req),
        .advance (w_advance),
        .sel     (w_sel)
    );

    always_comb begin
        w_next     = r_state;
        read       = 1'b0;
        write      = 1'b0;
        addr       = '0;
        data_write = '0;
        a.gnt      = 1'b0;
        a.err      = 1'b0;
        b.gnt      = 1'b0;
        b.err      = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (!BOOT_EN) begin
                    w_next = S_ARB;
                end else if (r_boot_go) begin
                    write      = 1'b1;
                    addr       = w_boot.addr;
                    data_write = w_boot.data;
                    if (r_idx == BOOT_IDX_W'(BOOT_LEN - 1)) w_next = S_ARB;
                end
            end
            S_ARB: begin
                if (w_any) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_next = S_ARB;
                if (w_in_range) begin
                    read       = ~r_we;
                    write      = r_we;
                    addr       = r_addr;
                    data_write = r_wdata;
                end
                a.gnt = w_issue_a;
                a.err = w_issue_a & ~w_in_range;
                b.gnt = w_issue_b;
                b.err = w_issue_b & ~w_in_range;
            end
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_idx       <= '0;
            r_boot_go   <= 1'b0;
            r_boot_done <= 1'b0;
            r_a_req     <= 1'b0;
            r_b_req     <= 1'b0;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_boot_go <= 1'b1;
            if (r_state == S_BOOT && r_boot_go) r_idx <= r_idx + 1'b1;
            if (r_state == S_BOOT && w_next == S_ARB) r_boot_done <= 1'b1;
            // A request still high in its own grant cycle must not count again.
            r_a_req <= a.req & ~w_issue_a;
            r_b_req <= b.req & ~w_issue_b;
            if (r_state == S_ARB && w_any) begin
                r_sel   <= w_sel;
                r_we    <= w_sel ? b.we    : a.we;
                r_addr  <= w_sel ? b.addr  : a.addr;
                r_wdata <= w_sel ? b.wdata : a.wdata;
            end
            r_a_rvalid <= w_issue_a & ~r_we;
            r_b_rvalid <= w_issue_b & ~r_we;
            if (w_issue_a && !r_we) r_a_rdata <= w_in_range ? data_read : '0;
            if (w_issue_b && !r_we) r_b_rdata <= w_in_range ? data_read : '0;
        end
    end

    assign a.rvalid  = r_a_rvalid;
    assign a.rdata   = r_a_rdata;
    assign b.rvalid  = r_b_rvalid;
    assign b.rdata   = r_b_rdata;
    assign boot_done = r_boot_done;
endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - directed plus randomized checks of reg_arbiter against a transaction-level model
module tb_reg_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read, write, boot_done;
    logic [5:0] addr;
    logic [7:0] data_write, data_read;

    logic [7:0] regs  [64];
    logic [7:0] mem_m [64];
    logic [5:0] boot_addr [4] = '{6'h00, 6'h02, 6'h03, 6'h04};
    logic [7:0] boot_data [4] = '{8'h00, 8'hFF, 8'h00, 8'h01};
    int         last_win_b = 1;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    reg_arbiter_if u_a ();
    reg_arbiter_if u_b ();

    reg_arbiter #(.BOOT_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (u_a),
        .b          (u_b),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .boot_done  (boot_done)
    );

    assign data_read = regs[addr];
    always @(posedge clk) if (write === 1'b1) regs[addr] <= data_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int p, input logic rq, input logic we, input logic [5:0] ad, input logic [7:0] wd);
        if (p == 0) begin
            u_a.req = rq; u_a.we = we; u_a.addr = ad; u_a.wdata = wd;
        end else begin
            u_b.req = rq; u_b.we = we; u_b.addr = ad; u_b.wdata = wd;
        end
    endtask

    function automatic logic gnt_of(input int p);    return (p != 0) ? u_b.gnt    : u_a.gnt;    endfunction
    function automatic logic err_of(input int p);    return (p != 0) ? u_b.err    : u_a.err;    endfunction
    function automatic logic rvalid_of(input int p); return (p != 0) ? u_b.rvalid : u_a.rvalid; endfunction
    function automatic logic [7:0] rdata_of(input int p); return (p != 0) ? u_b.rdata : u_a.rdata; endfunction

    task automatic wait_gnt(input int p, output int n);
        n = 0;
        @(negedge clk);
        while (gnt_of(p) !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_issue(input int p, input logic we, input logic [5:0] ad, input logic [7:0] wd,
                               output logic [7:0] exp_rd);
        logic ok;
        ok = (ad <= 6'h1F);
        exp_rd = ok ? mem_m[ad] : 8'h00;
        chk("gnt", gnt_of(p), 1);
        chk("err", err_of(p), !ok);
        chk("other_gnt", gnt_of(1 - p), 0);
        chk("read_strobe", read, ok && !we);
        chk("write_strobe", write, ok && we);
        if (ok) chk("addr", addr, ad);
        if (ok && we) begin
            chk("data_write", data_write, wd);
            mem_m[ad] = wd;
        end
    endtask

    task automatic check_resp(input int p, input logic we, input logic [7:0] exp_rd);
        chk("rvalid", rvalid_of(p), !we);
        if (!we) chk("rdata", rdata_of(p), exp_rd);
        chk("gnt_one_cycle", gnt_of(p), 0);
    endtask

    task automatic access(input int p, input logic we, input logic [5:0] ad, input logic [7:0] wd);
        int n;
        logic [7:0] exp_rd;
        @(posedge clk); #1 drive(p, 1'b1, we, ad, wd);
        wait_gnt(p, n);
        chk("latency", n, 2);
        check_issue(p, we, ad, wd, exp_rd);
        @(posedge clk); #1 drive(p, 1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        check_resp(p, we, exp_rd);
    endtask

    task automatic contend(input logic awe, input logic [5:0] aad, input logic [7:0] awd,
                           input logic bwe, input logic [5:0] bad, input logic [7:0] bwd);
        logic       pwe [2];
        logic [5:0] pad [2];
        logic [7:0] pwd [2];
        logic [7:0] exp_rd;
        int         w, l, n;
        pwe[0] = awe; pad[0] = aad; pwd[0] = awd;
        pwe[1] = bwe; pad[1] = bad; pwd[1] = bwd;
        w = (last_win_b != 0) ? 0 : 1;
        l = 1 - w;
        @(posedge clk); #1;
        drive(0, 1'b1, awe, aad, awd);
        drive(1, 1'b1, bwe, bad, bwd);
        wait_gnt(w, n);
        chk("cont_latency", n, 2);
        check_issue(w, pwe[w], pad[w], pwd[w], exp_rd);
        last_win_b = w;
        @(posedge clk); #1 drive(w, 1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        check_resp(w, pwe[w], exp_rd);
        chk("loser_waits", gnt_of(l), 0);
        wait_gnt(l, n);
        chk("loser_gap", n, 0);
        check_issue(l, pwe[l], pad[l], pwd[l], exp_rd);
        @(posedge clk); #1 drive(l, 1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        check_resp(l, pwe[l], exp_rd);
    endtask

    task automatic boot_seq(input logic pend);
        int n;
        logic [7:0] exp_rd;
        last_win_b = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dw", data_write, 0);
        chk("rst_boot_done", boot_done, 0);
        chk("rst_a_rvalid", u_a.rvalid, 0);
        chk("rst_a_rdata", u_a.rdata, 0);
        chk("rst_b_rdata", u_b.rdata, 0);
        chk("rst_gnt", {u_a.gnt, u_b.gnt, u_a.err, u_b.err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        if (pend) drive(0, 1'b1, 1'b0, 6'h02, 8'h00);
        n = 0;
        @(negedge clk);
        while (write !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            chk("boot_write", write, 1);
            chk("boot_addr", addr, boot_addr[i]);
            chk("boot_data", data_write, boot_data[i]);
            chk("boot_done_early", boot_done, 0);
            chk("boot_no_gnt", u_a.gnt, 0);
            mem_m[boot_addr[i]] = boot_data[i];
        end
        @(negedge clk);
        chk("boot_done", boot_done, 1);
        chk("boot_end_write", write, 0);
        if (pend) begin
            wait_gnt(0, n);
            check_issue(0, 1'b0, 6'h02, 8'h00, exp_rd);
            @(posedge clk); #1 drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
            @(negedge clk);
            check_resp(0, 1'b0, exp_rd);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            regs[i]  = 8'($urandom);
            mem_m[i] = regs[i];
        end
        drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 6'h00, 8'h00);

        boot_seq(1'b1);

        access(0, 1'b1, 6'h03, 8'h5A);
        access(0, 1'b0, 6'h03, 8'h00);

        contend(1'b1, 6'h05, 8'h11, 1'b1, 6'h06, 8'h22);
        contend(1'b1, 6'h05, 8'h33, 1'b1, 6'h06, 8'h44);
        access(0, 1'b0, 6'h05, 8'h00);
        access(1, 1'b0, 6'h06, 8'h00);

        access(1, 1'b0, 6'h25, 8'h00);
        access(0, 1'b1, 6'h3F, 8'h77);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                contend(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
            else
                access(int'($urandom_range(0, 1)), 1'($urandom), 6'($urandom), 8'($urandom));
        end

        access(0, 1'b1, 6'h10, 8'h3C);
        @(posedge clk); #1 drive(0, 1'b1, 1'b1, 6'h10, 8'hC3);
        wait_gnt(0, n);
        chk("pre_rst_write", write, 1);
        #1 rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
        #1;
        chk("mid_rst_write", write, 0);
        chk("mid_rst_gnt", u_a.gnt, 0);
        chk("mid_rst_boot_done", boot_done, 0);
        boot_seq(1'b0);
        access(1, 1'b0, 6'h10, 8'h00);
        contend(1'b0, 6'h02, 8'h00, 1'b0, 6'h04, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
